drum_accum_stage: RTL and testbench

//   Streaming accumulator that sits directly downstream of the 16x16 DRUM approximate multiplier.

---
 rtl/drum_accum_stage_pkg.sv | 17 +
 rtl/drum_accum_stage_if.sv | 30 +++
 rtl/drum_accum_stage_sat_add.sv | 17 +
 rtl/drum_accum_stage.sv | 103 ++++++++++
 tb/tb_drum_accum_stage.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/drum_accum_stage_pkg.sv
// Shared defaults, FSM state codes and small types for the DRUM product accumulator stage.
package drum_accum_stage_pkg;

    localparam int PROD_W_DEF = 32;
    localparam int ACC_W_DEF  = 40;
    localparam int CNT_W_DEF  = 16;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    // Saturation events raised by one accepted term.
    typedef struct packed {
        logic acc_sat;
        logic cnt_sat;
    } sat_flags_t;

endpackage

// File: rtl/drum_accum_stage_if.sv
// Product-in / sum-out handshake bundle of the accumulator stage.
interface drum_accum_stage_if
    import drum_accum_stage_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              clear;
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod_data;
    logic              prod_last;
    logic              sum_valid;
    logic              sum_ready;
    logic [ACC_W-1:0]  sum_data;
    logic [CNT_W-1:0]  sum_count;
    logic              sum_sat;

    modport master (
        output clear, prod_valid, prod_data, prod_last, sum_ready,
        input  prod_ready, sum_valid, sum_data, sum_count, sum_sat
    );

    modport slave (
        input  clear, prod_valid, prod_data, prod_last, sum_ready,
        output prod_ready, sum_valid, sum_data, sum_count, sum_sat
    );

endinterface

// File: rtl/drum_accum_stage_sat_add.sv
// Unsigned W-bit adder that clamps to all-ones on overflow and flags it.
module drum_accum_stage_sat_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);

    logic [W:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b};
    assign sat      = full_sum[W];
    assign sum      = full_sum[W] ? {W{1'b1}} : full_sum[W-1:0];

endmodule

// File: rtl/drum_accum_stage.sv
// Saturating streaming accumulator for DRUM multiplier products; one registered
// result (sum, term count, saturation flag) per group closed by prod_last.
module drum_accum_stage
    import drum_accum_stage_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input logic               clk,
    input logic               rst,
    drum_accum_stage_if.slave bus
);

    logic [0:0]       state_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             sat_reg;

    logic             sum_valid_reg;
    logic [ACC_W-1:0] sum_data_reg;
    logic [CNT_W-1:0] sum_count_reg;
    logic             sum_sat_reg;

    logic             accept;
    logic             accept_last;
    logic             accept_mid;
    logic [ACC_W-1:0] acc_base;
    logic [CNT_W-1:0] cnt_base;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic [ACC_W-1:0] prod_ext;
    sat_flags_t       new_sat;

    // A last term needs the output slot to be empty or emptying this very cycle.
    assign bus.prod_ready = !bus.clear &&
                            (!bus.prod_last || !sum_valid_reg || bus.sum_ready);

    assign accept      = bus.prod_valid && bus.prod_ready;
    assign accept_last = accept && bus.prod_last;
    assign accept_mid  = accept && !bus.prod_last;

    // A group always starts from zero, so IDLE ignores the running registers.
    assign acc_base = (state_reg == ST_IDLE) ? '0 : acc_reg;
    assign cnt_base = (state_reg == ST_IDLE) ? '0 : cnt_reg;
    assign prod_ext = ACC_W'(bus.prod_data);

    drum_accum_stage_sat_add #(.W(ACC_W)) u_acc_add (
        .a   (acc_base),
        .b   (prod_ext),
        .sum (acc_next),
        .sat (new_sat.acc_sat)
    );

    drum_accum_stage_sat_add #(.W(CNT_W)) u_cnt_add (
        .a   (cnt_base),
        .b   (CNT_W'(1)),
        .sum (cnt_next),
        .sat (new_sat.cnt_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            sat_reg   <= 1'b0;
        end else if (bus.clear || accept_last) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            sat_reg   <= 1'b0;
        end else if (accept_mid) begin
            state_reg <= ST_ACCUM;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            sat_reg   <= sat_reg | new_sat.acc_sat | new_sat.cnt_sat;
        end
    end

    // Output slot: a new result may overwrite a result being drained in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_valid_reg <= 1'b0;
            sum_data_reg  <= '0;
            sum_count_reg <= '0;
            sum_sat_reg   <= 1'b0;
        end else if (accept_last) begin
            sum_valid_reg <= 1'b1;
            sum_data_reg  <= acc_next;
            sum_count_reg <= cnt_next;
            sum_sat_reg   <= sat_reg | new_sat.acc_sat | new_sat.cnt_sat;
        end else if (sum_valid_reg && bus.sum_ready) begin
            sum_valid_reg <= 1'b0;
        end
    end

    assign bus.sum_valid = sum_valid_reg;
    assign bus.sum_data  = sum_data_reg;
    assign bus.sum_count = sum_count_reg;
    assign bus.sum_sat   = sum_sat_reg;

endmodule

// File: tb/tb_drum_accum_stage.sv
// Drives a default-width and a narrow (ACC_W=33, CNT_W=4) stage with identical
// stimulus and compares both against a group-level arithmetic reference.
module tb_drum_accum_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    drum_accum_stage_if #(.PROD_W(32), .ACC_W(40), .CNT_W(16)) bus ();
    drum_accum_stage_if #(.PROD_W(32), .ACC_W(33), .CNT_W(4))  bus_s ();

    drum_accum_stage #(.PROD_W(32), .ACC_W(40), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    drum_accum_stage #(.PROD_W(32), .ACC_W(33), .CNT_W(4)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    // Reference: running group total/term count plus one output slot per instance.
    longint unsigned m_acc [2];
    longint unsigned m_od  [2];
    int unsigned     m_cnt [2];
    int unsigned     m_oc  [2];
    bit              m_sat [2];
    bit              m_ov  [2];
    bit              m_os  [2];
    longint unsigned acc_max [2] = '{64'hFF_FFFF_FFFF, 64'h1_FFFF_FFFF};
    int unsigned     cnt_max [2] = '{65535, 15};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic bit model_ready(int k, bit clr, bit last, bit sr);
        return !clr && (!last || !m_ov[k] || sr);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
            m_od[k] = 0;  m_oc[k] = 0;  m_os[k] = 0; m_ov[k] = 0;
        end
    endtask

    task automatic model_step(int k, bit clr, bit v, longint unsigned d, bit last, bit sr);
        bit              acc_ok;
        longint unsigned tot;
        int unsigned     c;
        acc_ok = v && model_ready(k, clr, last, sr);
        tot = m_acc[k] + d;
        c   = m_cnt[k] + 1;
        if (acc_ok && last) begin
            m_od[k]  = (tot > acc_max[k]) ? acc_max[k] : tot;
            m_oc[k]  = (c > cnt_max[k]) ? cnt_max[k] : c;
            m_os[k]  = m_sat[k] || (tot > acc_max[k]) || (c > cnt_max[k]);
            m_ov[k]  = 1;
            m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
            if (k == 0) $display("group done: sum=0x%0h count=%0d sat=%0d", m_od[k], m_oc[k], m_os[k]);
        end else begin
            if (m_ov[k] && sr) m_ov[k] = 0;
            if (clr) begin
                m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
            end else if (acc_ok) begin
                m_sat[k] = m_sat[k] || (tot > acc_max[k]) || (c > cnt_max[k]);
                m_acc[k] = (tot > acc_max[k]) ? acc_max[k] : tot;
                m_cnt[k] = (c > cnt_max[k]) ? cnt_max[k] : c;
            end
        end
    endtask

    task automatic check_outs(input string ph);
        check({ph, " valid"},   bus.sum_valid,   m_ov[0]);
        check({ph, " data"},    bus.sum_data,    m_od[0]);
        check({ph, " count"},   bus.sum_count,   m_oc[0]);
        check({ph, " sat"},     bus.sum_sat,     m_os[0]);
        check({ph, " valid_s"}, bus_s.sum_valid, m_ov[1]);
        check({ph, " data_s"},  bus_s.sum_data,  m_od[1]);
        check({ph, " count_s"}, bus_s.sum_count, m_oc[1]);
        check({ph, " sat_s"},   bus_s.sum_sat,   m_os[1]);
    endtask

    task automatic drive(bit clr, bit v, longint unsigned d, bit last, bit sr);
        bus.clear = clr;   bus.prod_valid = v;   bus.prod_data = d[31:0];
        bus.prod_last = last;   bus.sum_ready = sr;
        bus_s.clear = clr; bus_s.prod_valid = v; bus_s.prod_data = d[31:0];
        bus_s.prod_last = last; bus_s.sum_ready = sr;
    endtask

    // One clock: drive, check ready before the edge, update model, check outputs after.
    task automatic cycle(bit clr, bit v, longint unsigned d, bit last, bit sr);
        @(negedge clk);
        drive(clr, v, d, last, sr);
        #1;
        check("prod_ready",   bus.prod_ready,   model_ready(0, clr, last, sr));
        check("prod_ready_s", bus_s.prod_ready, model_ready(1, clr, last, sr));
        @(posedge clk);
        model_step(0, clr, v, d, last, sr);
        model_step(1, clr, v, d, last, sr);
        #1;
        check_outs("cycle");
    endtask

    task automatic pulse_reset(input string ph);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        model_reset();
        check_outs(ph);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single-term group
        cycle(0, 1, 32'h1234, 1, 1);
        check("t1 sum", bus.sum_data, 40'h1234);
        check("t1 count", bus.sum_count, 1);
        cycle(0, 0, 0, 0, 1);

        // Four-term group
        cycle(0, 1, 100, 0, 1);
        cycle(0, 1, 200, 0, 1);
        cycle(0, 1, 300, 0, 1);
        cycle(0, 1, 400, 1, 1);
        check("t2 sum", bus.sum_data, 1000);
        check("t2 count", bus.sum_count, 4);
        cycle(0, 0, 0, 0, 1);

        // Backpressure with back-to-back reload
        cycle(0, 1, 5, 1, 0);
        cycle(0, 1, 7, 0, 0);
        cycle(0, 1, 9, 1, 0);
        check("t3 stall", bus.prod_ready, 0);
        cycle(0, 1, 9, 1, 0);
        cycle(0, 1, 9, 1, 1);
        check("t3 sum", bus.sum_data, 16);
        check("t3 valid", bus.sum_valid, 1);
        cycle(0, 0, 0, 0, 1);

        // Accumulator saturation on the narrow instance
        cycle(0, 1, 32'hFFFF_FFFF, 0, 1);
        cycle(0, 1, 32'hFFFF_FFFF, 0, 1);
        cycle(0, 1, 32'hFFFF_FFFF, 1, 1);
        check("t4 sum_s", bus_s.sum_data, 64'h1_FFFF_FFFF);
        check("t4 sat_s", bus_s.sum_sat, 1);
        check("t4 sum", bus.sum_data, 64'h2_FFFF_FFFD);
        cycle(0, 1, 2, 1, 1);
        check("t4 next sat_s", bus_s.sum_sat, 0);

        // Counter saturation on the narrow instance
        for (int i = 0; i < 20; i++) cycle(0, 1, 1, 0, 1);
        cycle(0, 1, 1, 1, 1);
        check("cnt sat count_s", bus_s.sum_count, 15);
        check("cnt sat sat_s", bus_s.sum_sat, 1);
        check("cnt count", bus.sum_count, 21);

        // Abort via clear, product held while clear is high
        cycle(0, 1, 10, 0, 1);
        cycle(0, 1, 20, 0, 1);
        cycle(1, 1, 5, 1, 1);
        check("t5 clear ready", bus.prod_ready, 0);
        cycle(0, 1, 5, 1, 1);
        check("t5 sum", bus.sum_data, 5);
        check("t5 count", bus.sum_count, 1);

        // Reset mid-group and during a pending result
        cycle(0, 1, 10, 0, 1);
        pulse_reset("rst mid");
        cycle(0, 1, 44, 1, 0);
        pulse_reset("rst hold");
        cycle(0, 1, 3, 1, 1);
        check("t6 sum", bus.sum_data, 3);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit clr, v, last, sr;
            longint unsigned d;
            clr  = ($urandom_range(0, 31) == 0);
            v    = ($urandom_range(0, 3) != 0);
            last = ($urandom_range(0, 7) == 0);
            sr   = ($urandom_range(0, 2) != 0);
            d    = ($urandom_range(0, 1) == 0) ? longint'($urandom) : longint'($urandom_range(0, 1000));
            cycle(clr, v, d, last, sr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
